// File: rtl/load_store_unit.sv
// Load/store unit: turns byte/half/word requests into whole-word RAM accesses with
// read-merge-write for sub-word stores. Define LSU_RANGE_CHECK_EN to reject out-of-range addresses.
module load_store_unit #(
    parameter int unsigned MEMORY_DEPTH = 64,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter logic [31:0] BASE_ADDR    = 32'h1001_0000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_write_i,
    input  logic [1:0]            req_size_i,
    input  logic                  req_signed_i,
    input  logic [DATA_WIDTH-1:0] req_addr_i,
    input  logic [DATA_WIDTH-1:0] req_wdata_i,
    output logic                  resp_valid_o,
    output logic [DATA_WIDTH-1:0] resp_rdata_o,
    output logic                  resp_error_o,
    output logic                  ram_we_o,
    output logic [DATA_WIDTH-1:0] ram_addr_o,
    output logic [DATA_WIDTH-1:0] ram_wdata_o,
    input  logic [DATA_WIDTH-1:0] ram_rdata_i
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] RESP   = 2'd2;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    logic [1:0]            state_q, state_d;
    logic [DATA_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [1:0]            size_q;
    logic                  signed_q;
    logic                  write_q;
    logic                  error_q;
    logic [DATA_WIDTH-1:0] resp_rdata_q;

    logic                  req_error;
    logic                  accept;
    logic                  store_go;
    logic [7:0]            ld_byte;
    logic [15:0]           ld_half;
    logic [DATA_WIDTH-1:0] load_data;
    logic [DATA_WIDTH-1:0] store_data;

`ifdef LSU_RANGE_CHECK_EN
    // 33-bit compare so BASE_ADDR + size cannot wrap past 2^32.
    localparam logic [32:0] RANGE_LO = {1'b0, BASE_ADDR};
    localparam logic [32:0] RANGE_HI = {1'b0, BASE_ADDR} + 33'(4 * MEMORY_DEPTH);
    logic [32:0] addr_ext;
    logic        out_of_range;

    always_comb begin
        addr_ext     = {1'b0, req_addr_i};
        out_of_range = (addr_ext < RANGE_LO) || (addr_ext >= RANGE_HI);
    end
`endif

    always_comb begin
        req_error = 1'b0;
        case (req_size_i)
            SIZE_BYTE: req_error = 1'b0;
            SIZE_HALF: req_error = req_addr_i[0];
            SIZE_WORD: req_error = |req_addr_i[1:0];
            default:   req_error = 1'b1;
        endcase
`ifdef LSU_RANGE_CHECK_EN
        if (out_of_range) begin
            req_error = 1'b1;
        end
`endif
    end

    assign accept = (state_q == IDLE) && req_valid_i;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_valid_i) state_d = ACCESS;
            ACCESS:  state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Lane extraction for loads, little-endian.
    always_comb begin
        ld_byte   = ram_rdata_i[{addr_q[1:0], 3'b000} +: 8];
        ld_half   = ram_rdata_i[{addr_q[1], 4'b0000} +: 16];
        load_data = ram_rdata_i;
        case (size_q)
            SIZE_BYTE: load_data = {{(DATA_WIDTH-8){signed_q & ld_byte[7]}}, ld_byte};
            SIZE_HALF: load_data = {{(DATA_WIDTH-16){signed_q & ld_half[15]}}, ld_half};
            default:   load_data = ram_rdata_i;
        endcase
    end

    // Read-merge-write: sub-word stores overlay the current RAM word.
    always_comb begin
        store_data = ram_rdata_i;
        case (size_q)
            SIZE_BYTE: store_data[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
            SIZE_HALF: store_data[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
            default:   store_data = wdata_q;
        endcase
    end

    // Gated by rst_n so a reset landing on ACCESS never commits the write.
    assign store_go = (state_q == ACCESS) && write_q && !error_q && rst_n;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            wdata_q      <= '0;
            size_q       <= 2'b00;
            signed_q     <= 1'b0;
            write_q      <= 1'b0;
            error_q      <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                addr_q   <= req_addr_i;
                wdata_q  <= req_wdata_i;
                size_q   <= req_size_i;
                signed_q <= req_signed_i;
                write_q  <= req_write_i;
                error_q  <= req_error;
            end
            if (state_q == ACCESS) begin
                resp_rdata_q <= (write_q || error_q) ? '0 : load_data;
            end
        end
    end

    always_comb begin
        req_ready_o  = (state_q == IDLE);
        resp_valid_o = (state_q == RESP);
        resp_error_o = (state_q == RESP) && error_q;
        resp_rdata_o = resp_rdata_q;
        ram_we_o     = store_go;
        ram_addr_o   = {addr_q[DATA_WIDTH-1:2], 2'b00};
        ram_wdata_o  = store_go ? store_data : '0;
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: a word RAM model, directed requests, and a monitor that
// checks every response and every RAM write against queued expectations.
module tb_load_store_unit;

    localparam logic [31:0] BASE = 32'h1001_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_signed = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;
    logic        ram_we;
    logic [31:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;

    int          n_cmp = 0;
    int          n_fail = 0;
    logic [31:0] cyc = '0;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic [31:0] cyc;
    } resp_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    resp_t exp_q[$];
    wr_t   wr_q[$];

    load_store_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_write_i  (req_write),
        .req_size_i   (req_size),
        .req_signed_i (req_signed),
        .req_addr_i   (req_addr),
        .req_wdata_i  (req_wdata),
        .resp_valid_o (resp_valid),
        .resp_rdata_o (resp_rdata),
        .resp_error_o (resp_error),
        .ram_we_o     (ram_we),
        .ram_addr_o   (ram_addr),
        .ram_wdata_o  (ram_wdata),
        .ram_rdata_i  (ram_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 32'd1;

    // RAM model: 64 words, index wraps.
    logic [31:0] mem [64] = '{default: 32'h0};
    logic [31:0] ram_off;
    assign ram_off   = ram_addr - BASE;
    assign ram_rdata = mem[ram_off[7:2]];
    always @(posedge clk) if (ram_we) mem[ram_off[7:2]] <= ram_wdata;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        resp_t r;
        wr_t   w;
        if (resp_valid) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_resp: got response rdata %h, expected none", resp_rdata);
            end else begin
                r = exp_q.pop_front();
                check("resp_rdata", resp_rdata, r.rdata);
                check("resp_error", {31'b0, resp_error}, {31'b0, r.err});
                check("resp_latency", cyc, r.cyc);
            end
        end
        if (ram_we) begin
            if (wr_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_write: got write %h to %h, expected none", ram_wdata,
                         ram_addr);
            end else begin
                w = wr_q.pop_front();
                check("ram_addr", ram_addr, w.addr);
                check("ram_wdata", ram_wdata, w.data);
            end
        end
    end

    task automatic wait_ready();
        int waited = 0;
        @(negedge clk);
        while (!req_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
    endtask

    // For stores exp_val is the merged RAM word (response data is 0); for loads it is the result.
    task automatic issue(input logic wr, input logic [1:0] sz, input logic sg,
                         input logic [31:0] ad, input logic [31:0] wd,
                         input logic [31:0] exp_val, input logic exp_err);
        resp_t r;
        wr_t   w;
        wait_ready();
        if (!req_ready) begin
            n_cmp++;
            n_fail++;
            $display("FAIL ready_timeout: got req_ready 0, expected 1");
            return;
        end
        r.rdata = (wr || exp_err) ? 32'h0 : exp_val;
        r.err   = exp_err;
        r.cyc   = cyc + 32'd2;
        exp_q.push_back(r);
        if (wr && !exp_err) begin
            w.addr = ad & ~32'h3;
            w.data = exp_val;
            wr_q.push_back(w);
        end
        req_write  = wr;
        req_size   = sz;
        req_signed = sg;
        req_addr   = ad;
        req_wdata  = wd;
        req_valid  = 1'b1;
        // Valid stays high into ACCESS; the next accept happens at the next IDLE edge.
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int waited;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_ready", {31'b0, req_ready}, 32'h1);
        check("rst_resp_valid", {31'b0, resp_valid}, 32'h0);
        check("rst_resp_error", {31'b0, resp_error}, 32'h0);
        check("rst_resp_rdata", resp_rdata, 32'h0);
        check("rst_ram_we", {31'b0, ram_we}, 32'h0);
        check("rst_ram_addr", ram_addr, 32'h0);

        // wr, size, signed, addr, wdata, expected, error
        issue(1, 2'b10, 0, 32'h1001_0004, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 0);
        issue(0, 2'b10, 0, 32'h1001_0004, 32'h0, 32'hDEAD_BEEF, 0);
        issue(1, 2'b10, 0, 32'h1001_0008, 32'h1122_3344, 32'h1122_3344, 0);
        issue(1, 2'b00, 0, 32'h1001_000A, 32'h0000_00AB, 32'h11AB_3344, 0);
        issue(0, 2'b10, 0, 32'h1001_0008, 32'h0, 32'h11AB_3344, 0);
        issue(0, 2'b00, 1, 32'h1001_000A, 32'h0, 32'hFFFF_FFAB, 0);
        issue(0, 2'b00, 0, 32'h1001_000A, 32'h0, 32'h0000_00AB, 0);
        issue(0, 2'b00, 1, 32'h1001_0008, 32'h0, 32'h0000_0044, 0);
        issue(1, 2'b10, 0, 32'h1001_000C, 32'h0, 32'h0, 0);
        issue(1, 2'b01, 0, 32'h1001_000E, 32'h0000_8001, 32'h8001_0000, 0);
        issue(0, 2'b01, 1, 32'h1001_000E, 32'h0, 32'hFFFF_8001, 0);
        issue(0, 2'b01, 0, 32'h1001_000E, 32'h0, 32'h0000_8001, 0);
        issue(0, 2'b01, 1, 32'h1001_000C, 32'h0, 32'h0000_0000, 0);

        // Misalignment and illegal size: error, no write, RAM unchanged.
        issue(1, 2'b10, 0, 32'h1001_0002, 32'h5555_5555, 32'h0, 1);
        issue(1, 2'b01, 0, 32'h1001_0001, 32'h5555_5555, 32'h0, 1);
        issue(1, 2'b11, 0, 32'h1001_0004, 32'h5555_5555, 32'h0, 1);
        issue(0, 2'b10, 0, 32'h1001_0006, 32'h0, 32'h0, 1);
        issue(0, 2'b10, 0, 32'h1001_0004, 32'h0, 32'hDEAD_BEEF, 0);
        issue(0, 2'b10, 0, 32'h1001_0000, 32'h0, 32'h0000_0000, 0);

`ifdef LSU_RANGE_CHECK_EN
        issue(1, 2'b10, 0, 32'h1001_0100, 32'h7777_7777, 32'h0, 1);
        issue(0, 2'b00, 0, 32'h1000_FFFF, 32'h0, 32'h0, 1);
`else
        // Out-of-range address passes through and the RAM index wraps to word 0.
        issue(1, 2'b10, 0, 32'h1001_0100, 32'h7777_7777, 32'h7777_7777, 0);
        issue(0, 2'b10, 0, 32'h1001_0000, 32'h0, 32'h7777_7777, 0);
`endif
        issue(1, 2'b10, 0, 32'h1001_00FC, 32'h1234_5678, 32'h1234_5678, 0);
        issue(0, 2'b10, 0, 32'h1001_00FC, 32'h0, 32'h1234_5678, 0);
        req_valid = 1'b0;

        // Reset lands on the ACCESS cycle of a store: nothing may be written or answered.
        wait_ready();
        req_write  = 1'b1;
        req_size   = 2'b10;
        req_signed = 1'b0;
        req_addr   = 32'h1001_0010;
        req_wdata  = 32'hCAFE_F00D;
        req_valid  = 1'b1;
        @(posedge clk);
        #1;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_resp_valid", {31'b0, resp_valid}, 32'h0);
        check("post_rst_ready", {31'b0, req_ready}, 32'h1);
        check("post_rst_ram_addr", ram_addr, 32'h0);
        issue(0, 2'b10, 0, 32'h1001_0010, 32'h0, 32'h0000_0000, 0);
        req_valid = 1'b0;

        waited = 0;
        while ((exp_q.size() != 0 || wr_q.size() != 0) && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        check("pending_resp", exp_q.size(), 32'h0);
        check("pending_writes", wr_q.size(), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits between the core's memory stage and the word-organised data RAM (byte address, base 0x1001_0000, combinational read, synchronous write).
- Turns byte, halfword and word loads and stores into whole-word RAM accesses. Sub-word stores become read-merge-write.
- Checks alignment (and, optionally, address range) before touching the RAM. Returns one response per request over a valid/ready handshake.

Parameters:
- MEMORY_DEPTH, 64, number of 32-bit words in the downstream RAM.
- DATA_WIDTH, 32, data and address width. Only 32 is supported.
- BASE_ADDR, 32'h1001_0000, byte address of RAM word 0.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- req_valid_i  input  1  core presents a request.
- req_ready_o  output  1  LSU can accept a request.
- req_write_i  input  1  1 = store, 0 = load.
- req_size_i  input  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
- req_signed_i  input  1  sign-extend sub-word loads.
- req_addr_i  input  DATA_WIDTH  byte address.
- req_wdata_i  input  DATA_WIDTH  store data, right-justified.
- resp_valid_o  output  1  one-cycle response pulse.
- resp_rdata_o  output  DATA_WIDTH  load result.
- resp_error_o  output  1  request rejected; RAM untouched.
- ram_we_o  output  1  RAM write enable.
- ram_addr_o  output  DATA_WIDTH  word-aligned byte address to RAM (addr & ~3).
- ram_wdata_o  output  DATA_WIDTH  merged write word.
- ram_rdata_i  input  DATA_WIDTH  combinational RAM read data.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state = IDLE.
  - resp_valid_o = 0, resp_error_o = 0, resp_rdata_o = 0, ram_we_o = 0.
  - All latched request fields = 0, so ram_addr_o = 0.
  - Reset mid-operation drops the pending request. No RAM write occurs in the reset cycle.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - req_ready_o = 1.
  - If req_valid_i=1 at the edge: latch addr, size, signed, write and wdata; compute the error flag; go to ACCESS.
  - Otherwise remain in IDLE.
- ACCESS:
  - req_ready_o = 0.
  - ram_addr_o = latched addr with bits [1:0] cleared.
  - Store without error: ram_we_o = 1 for exactly this cycle; ram_wdata_o = merge(ram_rdata_i, wdata).
  - Load without error: extract the lane from ram_rdata_i and register it into resp_rdata_o.
  - Error: ram_we_o = 0 and resp_rdata_o <= 0.
  - Stores always register resp_rdata_o <= 0.
  - Next state: RESP.
- RESP:
  - resp_valid_o = 1 and resp_error_o = latched error for exactly one cycle. No backpressure on responses.
  - Next state: IDLE.
- Latency and throughput:
  - A request accepted at edge E0 gets resp_valid_o high between edges E1 and E2.
  - One request per 3 cycles.
  - req_valid_i held high after a response is accepted again at the next IDLE edge.
- Lanes (little-endian):
  - Byte lane = addr[1:0]; halfword lane = addr[1].
  - Byte merge replaces bits [8*lane+7 : 8*lane] with wdata[7:0]. Halfword merge replaces [16*addr[1]+15 : 16*addr[1]] with wdata[15:0]. Word store writes wdata unmerged.
  - Loads zero-extend, or sign-extend from bit 7 or bit 15 when req_signed_i=1.
- Errors (any one sets the error flag):
  - size = 11.
  - Halfword with addr[0] = 1.
  - Word with addr[1:0] != 0.
  - The range check under the optional feature.
- ram_addr_o and ram_wdata_o hold their last values outside ACCESS. ram_wdata_o = 0 when not storing.

Optional Feature:
- Macro: LSU_RANGE_CHECK_EN.
- Defined: the error flag is also set when addr < BASE_ADDR or addr >= BASE_ADDR + 4*MEMORY_DEPTH, using unsigned 32-bit comparison with no wrap-around.
- Undefined: only alignment and size are checked. Out-of-range addresses go to the RAM unchanged and the RAM's index wraps.

Test Plan:
- Word store: addr 0x1001_0004, wdata 0xDEAD_BEEF, size 10 → ram_we_o high for exactly 1 cycle with ram_addr_o 0x1001_0004. A following word load from the same address → resp_rdata_o 0xDEAD_BEEF, resp_error_o 0, resp_valid_o 2 cycles after the accept edge.
- Byte store: word at 0x1001_0008 = 0x1122_3344; store byte 0xAB at 0x1001_000A → word becomes 0x11AB_3344. Signed byte load from 0x1001_000A → 0xFFFF_FFAB; unsigned → 0x0000_00AB.
- Halfword: store 0x8001 at 0x1001_000E over 0x0000_0000 → word 0x8001_0000. Signed half load → 0xFFFF_8001.
- Misalignment: word store to 0x1001_0002, half store to 0x1001_0001, size 11 → resp_error_o 1, ram_we_o never asserted, RAM contents unchanged.
- Range, with LSU_RANGE_CHECK_EN: word store to 0x1001_0100 (= BASE + 4*64) → error, no write. Store to 0x1001_00FC → succeeds.
- Reset: assert rst_n=0 during ACCESS of a store → no write, resp_valid_o 0, req_ready_o 1 on the first cycle after release.
